id_slice: RTL and testbench
===========================

ID_SLICE -- requirements
Module: id_slice

Interface
REQ-001 Parameters: none; widths fixed (16-bit data/instr, 4-bit register index).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_pc_inc  in  16  PC+4 from fetch stage.
REQ-005 if_instr  in  16  fetched instruction.
REQ-006 flush  in  1  taken branch/call/return resolved in EX; squash IF/ID contents.
REQ-007 ex_valid, ex_mem_rd  in  1 each  EX-stage instruction valid; EX-stage instruction is a load.
REQ-008 ex_rd  in  4  EX-stage destination register.
REQ-009 wb_we  in  1, wb_rd  in  4, wb_data  in  16  write-back port.
REQ-010 stall  out  1  hold PC and fetch; high for a load-use hazard.
REQ-011 id_valid  out  1  decoded instruction is live (not bubble).
REQ-012 id_pc_inc  out  16; id_rs, id_rt, id_rd  out  4 each; id_rs_data, id_rt_data  out  16 each; id_imm  out  16.
REQ-013 id_reg_we, id_mem_rd, id_mem_wr, id_alu_imm, id_branch, id_halt  out  1 each; id_aluop  out  3.

Function
REQ-014 Instruction fields: opcode[15:12], rd[11:8], rs[7:4], rt[3:0], imm8[7:0].
REQ-015 Opcodes 0x0-0x7: ALU, id_aluop=opcode[2:0], id_reg_we=1; 0x8 LW (mem_rd, reg_we, alu_imm); 0x9 SW (mem_wr, alu_imm, rt=rd field as store source); 0xA/0xB LHB/LLB (reg_we, alu_imm); 0xC B, 0xD CALL (branch; CALL reg_we to R15); 0xE RET (branch, rs=R15); 0xF HLT (halt).
REQ-016 id_imm = sign-extended imm8 for LW/SW/B; zero-extended imm8 otherwise.
REQ-017 IF/ID register captures if_pc_inc, if_instr, valid=1 each cycle when stall=0 and flush=0.
REQ-018 flush=1: next IF/ID valid=0 regardless of stall; flush has priority over stall.
REQ-019 stall = id_valid & ex_valid & ex_mem_rd & (ex_rd!=0) & (ex_rd matches a source register the current opcode actually reads).
REQ-020 stall=1: IF/ID holds contents; outputs for that cycle forced to bubble (id_valid=0, all control outputs 0).
REQ-021 When IF/ID valid=0, all control outputs SHALL be 0; data outputs are don't-care.
REQ-022 Register file: 16x16, write on rising edge when wb_we=1 and wb_rd!=0; R0 reads 0 always.
REQ-023 Register reads combinational from IF/ID fields; decode path is combinational, zero added latency beyond IF/ID register.
REQ-024 Halted: after an HLT passes ID with id_valid=1, no further change; halt state is owned downstream, id_slice keeps decoding.

Reset
REQ-025 rst: IF/ID valid=0, pc_inc=0, instr=0; all 16 registers =0; stall=0; all control outputs 0.
REQ-026 rst asserted mid-operation discards pending write-back and in-flight instruction immediately.

Configuration
REQ-027 Macro ID_WB_BYPASS_EN defined: read of register equal to wb_rd with wb_we=1 (rd!=0) returns wb_data same cycle.
REQ-028 ID_WB_BYPASS_EN undefined: such a read returns old stored value; stall additionally asserts for that same-cycle match.

Structure
REQ-029 Shared package cpu_pkg: opcode enum, field-position constants, aluop encoding, control-bundle struct.
REQ-030 One sub-module: id_regfile (16x16, two read ports, one write port, bypass under macro).

Verification
REQ-031 Reset, then if_instr=0x1234 -> next cycle id_valid=1, id_aluop=1, id_rd=2, id_rs=3, id_rt=4, id_reg_we=1.
REQ-032 wb_we=1 wb_rd=5 wb_data=0xBEEF, then instr rs=5 -> id_rs_data=0xBEEF; wb_rd=0 write -> R0 still reads 0.
REQ-033 EX LW ex_rd=3, ID instr reading rs=3 -> stall=1 one cycle, bubble out, IF/ID unchanged; next cycle normal decode.
REQ-034 flush=1 with stall=1 same cycle -> next cycle id_valid=0, stall=0.
REQ-035 LW imm8=0xF0 -> id_imm=0xFFF0; LLB imm8=0xF0 -> id_imm=0x00F0.
REQ-036 Same-cycle WB write and read of R7: with ID_WB_BYPASS_EN new value; without, stall=1 then new value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the decode slice and its register file.
// Contents: opcode and ALU-op encodings, instruction field positions, register-file
// geometry, the decoded control bundle and a helper that decodes it from an opcode.
package cpu_pkg;

  localparam int unsigned DataW    = 16;
  localparam int unsigned RegAddrW = 4;
  localparam int unsigned NumRegs  = 16;

  // Instruction field positions
  localparam int unsigned OpcMsb = 15;
  localparam int unsigned OpcLsb = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 8;
  localparam int unsigned RsMsb  = 7;
  localparam int unsigned RsLsb  = 4;
  localparam int unsigned RtMsb  = 3;
  localparam int unsigned RtLsb  = 0;
  localparam int unsigned ImmMsb = 7;

  // Link register used implicitly by CALL (write) and RET (read)
  localparam logic [RegAddrW-1:0] LinkReg = 4'd15;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpSll  = 4'h5,
    OpSrl  = 4'h6,
    OpSra  = 4'h7,
    OpLw   = 4'h8,
    OpSw   = 4'h9,
    OpLhb  = 4'hA,
    OpLlb  = 4'hB,
    OpB    = 4'hC,
    OpCall = 4'hD,
    OpRet  = 4'hE,
    OpHlt  = 4'hF
  } opcode_e;

  // ALU opcodes map 1:1 onto opcode[2:0]; non-ALU instructions use AluAdd
  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSra = 3'd7
  } aluop_e;

  typedef struct packed {
    logic   reg_we;
    logic   mem_rd;
    logic   mem_wr;
    logic   alu_imm;
    logic   branch;
    logic   halt;
    aluop_e aluop;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(logic [3:0] opc);
    ctrl_t c;
    c = '0;
    if (!opc[3]) begin
      c.reg_we = 1'b1;
      c.aluop  = aluop_e'(opc[2:0]);
    end else begin
      case (opcode_e'(opc))
        OpLw:         begin c.mem_rd = 1'b1; c.reg_we = 1'b1; c.alu_imm = 1'b1; end
        OpSw:         begin c.mem_wr = 1'b1; c.alu_imm = 1'b1; end
        OpLhb, OpLlb: begin c.reg_we = 1'b1; c.alu_imm = 1'b1; end
        OpB, OpRet:   c.branch = 1'b1;
        OpCall:       begin c.branch = 1'b1; c.reg_we = 1'b1; end
        OpHlt:        c.halt = 1'b1;
        default:      c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 16x16 register file: two combinational read ports, one synchronous write port.
// R0 is hardwired to zero. With ID_WB_BYPASS_EN defined, a read of the register being
// written this cycle returns the write data; otherwise it returns the stored value.
// Ports: clk, rst (async, active-high), i_we/i_wr_addr/i_wr_data write port,
// i_rd_addr_a/b read addresses, o_rd_data_a/b read data.
module id_regfile
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [RegAddrW-1:0] i_wr_addr,
  input  logic [DataW-1:0]    i_wr_data,
  input  logic [RegAddrW-1:0] i_rd_addr_a,
  input  logic [RegAddrW-1:0] i_rd_addr_b,
  output logic [DataW-1:0]    o_rd_data_a,
  output logic [DataW-1:0]    o_rd_data_b
);

  logic [DataW-1:0] r_regs [NumRegs];
  logic             w_wr_en;

  assign w_wr_en = i_we && (i_wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
`ifdef ID_WB_BYPASS_EN
    if (w_wr_en && (i_rd_addr_a == i_wr_addr)) o_rd_data_a = i_wr_data;
    if (w_wr_en && (i_rd_addr_b == i_wr_addr)) o_rd_data_b = i_wr_data;
`endif
  end

endmodule

// File: rtl/id_slice.sv
// Instruction-decode slice: IF/ID pipeline register, combinational decode, register-file
// read and load-use hazard detection.
// Config macro: ID_WB_BYPASS_EN -- when defined, same-cycle write-back is bypassed to the
// read ports; when undefined, a same-cycle write-back to a source register stalls ID.
// Ports: clk, rst (async, active-high); i_if_* fetch inputs; i_flush squashes IF/ID;
// i_ex_* describe the EX-stage instruction; i_wb_* write-back port; o_stall holds fetch;
// o_id_* decoded instruction, operands and control (control all 0 when not o_id_valid).
module id_slice
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_if_pc_inc,
  input  logic [15:0] i_if_instr,
  input  logic        i_flush,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_rd,
  input  logic [3:0]  i_ex_rd,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_rd,
  input  logic [15:0] i_wb_data,
  output logic        o_stall,
  output logic        o_id_valid,
  output logic [15:0] o_id_pc_inc,
  output logic [3:0]  o_id_rs,
  output logic [3:0]  o_id_rt,
  output logic [3:0]  o_id_rd,
  output logic [15:0] o_id_rs_data,
  output logic [15:0] o_id_rt_data,
  output logic [15:0] o_id_imm,
  output logic        o_id_reg_we,
  output logic        o_id_mem_rd,
  output logic        o_id_mem_wr,
  output logic        o_id_alu_imm,
  output logic        o_id_branch,
  output logic        o_id_halt,
  output logic [2:0]  o_id_aluop
);

  logic        r_valid;
  logic [15:0] r_pc_inc;
  logic [15:0] r_instr;

  logic [3:0]  w_opc;
  logic [3:0]  w_rs_idx, w_rt_idx, w_rd_idx;
  logic        w_reads_rs, w_reads_rt, w_imm_sext;
  logic        w_ex_hit, w_wb_hit, w_stall, w_live;
  ctrl_t       w_ctrl;

  // Flush wins over stall; a stall simply holds the register contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_pc_inc <= '0;
      r_instr  <= '0;
    end else if (i_flush) begin
      r_valid  <= 1'b0;
    end else if (!w_stall) begin
      r_valid  <= 1'b1;
      r_pc_inc <= i_if_pc_inc;
      r_instr  <= i_if_instr;
    end
  end

  assign w_opc = r_instr[OpcMsb:OpcLsb];

  // Register indices and which sources this opcode really reads (drives hazard checks)
  always_comb begin
    w_rs_idx   = r_instr[RsMsb:RsLsb];
    w_rt_idx   = r_instr[RtMsb:RtLsb];
    w_rd_idx   = r_instr[RdMsb:RdLsb];
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_imm_sext = 1'b0;
    case (opcode_e'(w_opc))
      OpLw: begin
        w_reads_rs = 1'b1;
        w_imm_sext = 1'b1;
      end
      OpSw: begin
        // Store data comes from the rd field, routed out on the rt port
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        w_rt_idx   = r_instr[RdMsb:RdLsb];
        w_imm_sext = 1'b1;
      end
      OpB:    w_imm_sext = 1'b1;
      OpCall: w_rd_idx   = LinkReg;
      OpRet: begin
        w_reads_rs = 1'b1;
        w_rs_idx   = LinkReg;
      end
      OpLhb, OpLlb, OpHlt: w_imm_sext = 1'b0;
      default: begin
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
      end
    endcase
  end

  assign w_ex_hit = (w_reads_rs && (w_rs_idx == i_ex_rd)) || (w_reads_rt && (w_rt_idx == i_ex_rd));
  assign w_wb_hit = (w_reads_rs && (w_rs_idx == i_wb_rd)) || (w_reads_rt && (w_rt_idx == i_wb_rd));

`ifdef ID_WB_BYPASS_EN
  assign w_stall = r_valid && i_ex_valid && i_ex_mem_rd && (i_ex_rd != '0) && w_ex_hit;
`else
  // Without bypass the read sees the old value, so wait one cycle for the write to land
  assign w_stall = r_valid && ((i_ex_valid && i_ex_mem_rd && (i_ex_rd != '0) && w_ex_hit) ||
                               (i_wb_we && (i_wb_rd != '0) && w_wb_hit));
`endif

  assign w_live = r_valid && !w_stall;
  assign w_ctrl = w_live ? decode_ctrl(w_opc) : '0;

  id_regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_we        (i_wb_we),
    .i_wr_addr   (i_wb_rd),
    .i_wr_data   (i_wb_data),
    .i_rd_addr_a (w_rs_idx),
    .i_rd_addr_b (w_rt_idx),
    .o_rd_data_a (o_id_rs_data),
    .o_rd_data_b (o_id_rt_data)
  );

  assign o_stall      = w_stall;
  assign o_id_valid   = w_live;
  assign o_id_pc_inc  = r_pc_inc;
  assign o_id_rs      = w_rs_idx;
  assign o_id_rt      = w_rt_idx;
  assign o_id_rd      = w_rd_idx;
  assign o_id_imm     = w_imm_sext ? {{8{r_instr[ImmMsb]}}, r_instr[ImmMsb:0]}
                                   : {8'h00, r_instr[ImmMsb:0]};
  assign o_id_reg_we  = w_ctrl.reg_we;
  assign o_id_mem_rd  = w_ctrl.mem_rd;
  assign o_id_mem_wr  = w_ctrl.mem_wr;
  assign o_id_alu_imm = w_ctrl.alu_imm;
  assign o_id_branch  = w_ctrl.branch;
  assign o_id_halt    = w_ctrl.halt;
  assign o_id_aluop   = w_ctrl.aluop;

endmodule

// File: tb/tb_id_slice.sv
// Scoreboard bench for id_slice: stimulus pushes expected per-cycle ID outputs into a
// queue tagged with the cycle they apply to; a monitor pops and compares on negedges.
module tb_id_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc_inc, if_instr;
  logic        flush, ex_valid, ex_mem_rd, wb_we;
  logic [3:0]  ex_rd, wb_rd;
  logic [15:0] wb_data;
  logic        stall, id_valid;
  logic [15:0] id_pc_inc, id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_reg_we, id_mem_rd, id_mem_wr, id_alu_imm, id_branch, id_halt;
  logic [2:0]  id_aluop;

  id_slice dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_pc_inc  (if_pc_inc),
    .i_if_instr   (if_instr),
    .i_flush      (flush),
    .i_ex_valid   (ex_valid),
    .i_ex_mem_rd  (ex_mem_rd),
    .i_ex_rd      (ex_rd),
    .i_wb_we      (wb_we),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .o_stall      (stall),
    .o_id_valid   (id_valid),
    .o_id_pc_inc  (id_pc_inc),
    .o_id_rs      (id_rs),
    .o_id_rt      (id_rt),
    .o_id_rd      (id_rd),
    .o_id_rs_data (id_rs_data),
    .o_id_rt_data (id_rt_data),
    .o_id_imm     (id_imm),
    .o_id_reg_we  (id_reg_we),
    .o_id_mem_rd  (id_mem_rd),
    .o_id_mem_wr  (id_mem_wr),
    .o_id_alu_imm (id_alu_imm),
    .o_id_branch  (id_branch),
    .o_id_halt    (id_halt),
    .o_id_aluop   (id_aluop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic        stall;
    logic        valid;
    logic [8:0]  ctrl;
    bit          chk;
    logic [3:0]  rd, rs, rt;
    logic [15:0] pc, imm, rs_data, rt_data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {reg_we, mem_rd, mem_wr, alu_imm, branch, halt, aluop}
  function automatic logic [8:0] ctl(bit we, bit mr, bit mw, bit ai, bit br, bit ht,
                                     logic [2:0] op);
    return {we, mr, mw, ai, br, ht, op};
  endfunction

  task automatic push(int c, int id, logic st, logic v, logic [8:0] ct, bit ck,
                      logic [3:0] rd, logic [3:0] rs, logic [3:0] rt,
                      logic [15:0] pc, logic [15:0] imm, logic [15:0] rsd, logic [15:0] rtd);
    exp_t e;
    e.cyc = c; e.id = id; e.stall = st; e.valid = v; e.ctrl = ct; e.chk = ck;
    e.rd = rd; e.rs = rs; e.rt = rt; e.pc = pc; e.imm = imm; e.rs_data = rsd; e.rt_data = rtd;
    sb.push_back(e);
  endtask

  task automatic push_bubble(int c, int id, logic st);
    push(c, id, st, 1'b0, 9'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic push_dec(int c, int id, logic [8:0] ct, logic [3:0] rd, logic [3:0] rs,
                          logic [3:0] rt, logic [15:0] pc, logic [15:0] imm,
                          logic [15:0] rsd, logic [15:0] rtd);
    push(c, id, 1'b0, 1'b1, ct, 1'b1, rd, rs, rt, pc, imm, rsd, rtd);
  endtask

  task automatic check(string nm, int id, logic [15:0] act, logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s vec%0d cyc%0d: got %h expected %h", nm, id, cyc, act, expv);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          check("missed", e.id, 16'(cyc), 16'(e.cyc));
        end else begin
          check("stall", e.id, {15'b0, stall}, {15'b0, e.stall});
          check("valid", e.id, {15'b0, id_valid}, {15'b0, e.valid});
          check("ctrl", e.id,
                {7'b0, id_reg_we, id_mem_rd, id_mem_wr, id_alu_imm, id_branch, id_halt, id_aluop},
                {7'b0, e.ctrl});
          if (e.chk) begin
            check("rd", e.id, {12'b0, id_rd}, {12'b0, e.rd});
            check("rs", e.id, {12'b0, id_rs}, {12'b0, e.rs});
            check("rt", e.id, {12'b0, id_rt}, {12'b0, e.rt});
            check("pc_inc", e.id, id_pc_inc, e.pc);
            check("imm", e.id, id_imm, e.imm);
            check("rs_data", e.id, id_rs_data, e.rs_data);
            check("rt_data", e.id, id_rt_data, e.rt_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(logic [15:0] instr, logic [15:0] pc);
    if_instr  = instr;
    if_pc_inc = pc;
  endtask

  task automatic set_wb(logic we, logic [3:0] rd, logic [15:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_ex(logic v, logic mr, logic [3:0] rd);
    ex_valid = v; ex_mem_rd = mr; ex_rd = rd;
  endtask

  // Stimulus
  initial begin
    int guard;
    rst = 1'b1; flush = 1'b0;
    set_if(16'h0, 16'h0); set_wb(1'b0, 4'h0, 16'h0); set_ex(1'b0, 1'b0, 4'h0);
    tick(); tick();
    push(cyc, 0, 1'b0, 1'b0, 9'h0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    tick(); rst = 1'b0; set_if(16'h1234, 16'h0004);
    push_dec(cyc + 1, 1, ctl(1, 0, 0, 0, 0, 0, 3'd1), 4'h2, 4'h3, 4'h4, 16'h0004, 16'h0034,
             16'h0, 16'h0);

    tick(); set_if(16'h0250, 16'h0008); set_wb(1'b1, 4'h5, 16'hBEEF);
    push_dec(cyc + 1, 2, ctl(1, 0, 0, 0, 0, 0, 3'd0), 4'h2, 4'h5, 4'h0, 16'h0008, 16'h0050,
             16'hBEEF, 16'h0);

    tick(); set_if(16'h3700, 16'h000C); set_wb(1'b1, 4'h0, 16'h1111);
    push_dec(cyc + 1, 3, ctl(1, 0, 0, 0, 0, 0, 3'd3), 4'h7, 4'h0, 4'h0, 16'h000C, 16'h0000,
             16'h0, 16'h0);

    tick(); set_if(16'h1130, 16'h0010); set_wb(1'b0, 4'h0, 16'h0);

    // Load-use on R3: one bubble, IF/ID holds 0x1130
    tick(); set_if(16'h2222, 16'h0014); set_ex(1'b1, 1'b1, 4'h3);
    push_bubble(cyc, 4, 1'b1);
    push_dec(cyc + 1, 5, ctl(1, 0, 0, 0, 0, 0, 3'd1), 4'h1, 4'h3, 4'h0, 16'h0010, 16'h0030,
             16'h0, 16'h0);

    tick(); set_ex(1'b0, 1'b0, 4'h0);

    // Load-use on R2 together with flush
    tick(); set_if(16'h3333, 16'h0018); set_ex(1'b1, 1'b1, 4'h2); flush = 1'b1;
    push_bubble(cyc, 6, 1'b1);
    push_bubble(cyc + 1, 7, 1'b0);

    tick(); set_ex(1'b0, 1'b0, 4'h0); flush = 1'b0; set_if(16'h8AF0, 16'h001C);
    push_dec(cyc + 1, 8, ctl(1, 1, 0, 1, 0, 0, 3'd0), 4'hA, 4'hF, 4'h0, 16'h001C, 16'hFFF0,
             16'h0, 16'h0);

    tick(); set_if(16'hB3F0, 16'h0020);
    push_dec(cyc + 1, 9, ctl(1, 0, 0, 1, 0, 0, 3'd0), 4'h3, 4'hF, 4'h0, 16'h0020, 16'h00F0,
             16'h0, 16'h0);

    tick(); set_if(16'h9681, 16'h0024);
    push_dec(cyc + 1, 10, ctl(0, 0, 1, 1, 0, 0, 3'd0), 4'h6, 4'h8, 4'h6, 16'h0024, 16'hFF81,
             16'h0, 16'h0);

    tick(); set_if(16'hE000, 16'h0028);
    push_dec(cyc + 1, 11, ctl(0, 0, 0, 0, 1, 0, 3'd0), 4'h0, 4'hF, 4'h0, 16'h0028, 16'h0000,
             16'h0, 16'h0);

    tick(); set_if(16'hD0FE, 16'h002C);
    push_dec(cyc + 1, 12, ctl(1, 0, 0, 0, 1, 0, 3'd0), 4'hF, 4'hF, 4'hE, 16'h002C, 16'h00FE,
             16'h0, 16'h0);

    tick(); set_if(16'hF000, 16'h0030);
    push_dec(cyc + 1, 13, ctl(0, 0, 0, 0, 0, 1, 3'd0), 4'h0, 4'h0, 4'h0, 16'h0030, 16'h0000,
             16'h0, 16'h0);

    tick(); set_if(16'hCFF0, 16'h0034);
    push_dec(cyc + 1, 14, ctl(0, 0, 0, 0, 1, 0, 3'd0), 4'hF, 4'hF, 4'h0, 16'h0034, 16'hFFF0,
             16'h0, 16'h0);

    tick(); set_if(16'h0170, 16'h0040);

    // Same-cycle write-back of R7 while ID reads it
    tick(); set_if(16'h0170, 16'h0044); set_wb(1'b1, 4'h7, 16'h1357);
`ifdef ID_WB_BYPASS_EN
    push_dec(cyc, 15, ctl(1, 0, 0, 0, 0, 0, 3'd0), 4'h1, 4'h7, 4'h0, 16'h0040, 16'h0070,
             16'h1357, 16'h0);
    push_dec(cyc + 1, 16, ctl(1, 0, 0, 0, 0, 0, 3'd0), 4'h1, 4'h7, 4'h0, 16'h0044, 16'h0070,
             16'h1357, 16'h0);
`else
    push_bubble(cyc, 15, 1'b1);
    push_dec(cyc + 1, 16, ctl(1, 0, 0, 0, 0, 0, 3'd0), 4'h1, 4'h7, 4'h0, 16'h0040, 16'h0070,
             16'h1357, 16'h0);
`endif

    tick(); set_wb(1'b0, 4'h0, 16'h0); set_if(16'h0000, 16'h0048);

    // Mid-run reset with a write-back pending: both discarded
    tick(); rst = 1'b1; set_wb(1'b1, 4'h9, 16'hAAAA); set_if(16'h1095, 16'h0050);
    push(cyc, 17, 1'b0, 1'b0, 9'h0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    tick(); rst = 1'b0; set_wb(1'b0, 4'h0, 16'h0);
    push_dec(cyc + 1, 18, ctl(1, 0, 0, 0, 0, 0, 3'd1), 4'h0, 4'h9, 4'h5, 16'h0050, 16'h0095,
             16'h0, 16'h0);

    tick(); tick();
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
